// File: rtl/hysteresis_threshold.sv
// Canny double threshold with iterative in-place hysteresis.
// Classify, promote WEAK neighbours of STRONG pixels, then emit the edge map.
module hysteresis_threshold #(
    parameter int FRAME_WIDTH  = 640,
    parameter int FRAME_HEIGHT = 480,
    parameter int PIX_WIDTH    = 24,
    parameter int MAX_PASSES   = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          thin_val,
    input  logic [PIX_WIDTH/3-1:0]        thin_edge [FRAME_HEIGHT][FRAME_WIDTH],
    input  logic [PIX_WIDTH/3-1:0]        low_thr,
    input  logic [PIX_WIDTH/3-1:0]        high_thr,
    output logic                          busy,
    output logic                          canny_val,
    output logic [PIX_WIDTH/3-1:0]        canny_edge [FRAME_HEIGHT][FRAME_WIDTH],
    output logic [$clog2(MAX_PASSES):0]   pass_cnt
);
    localparam int MW = PIX_WIDTH / 3;
    localparam int W  = FRAME_WIDTH;
    localparam int H  = FRAME_HEIGHT;
    localparam int XW = $clog2(W);
    localparam int YW = $clog2(H);
    localparam int PW = $clog2(MAX_PASSES) + 1;

    localparam logic [XW-1:0] X_LAST  = XW'(W - 1);
    localparam logic [YW-1:0] Y_LAST  = YW'(H - 1);
    localparam logic [XW-1:0] X_HLAST = XW'(W - 2);
    localparam logic [YW-1:0] Y_HLAST = YW'(H - 2);
    localparam logic [XW-1:0] X_ONE   = XW'(1);
    localparam logic [YW-1:0] Y_ONE   = YW'(1);
    localparam logic [PW-1:0] P_MAX   = PW'(MAX_PASSES);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CLASSIFY,
        S_HYST,
        S_OUTPUT
    } state_e;

    typedef enum logic [1:0] {
        C_NONE,
        C_WEAK,
        C_STRONG
    } cls_e;

    state_e          state_q;
    logic            thin_val_q;
    logic [XW-1:0]   x_q;
    logic [YW-1:0]   y_q;
    logic [MW-1:0]   lo_q;
    logic [MW-1:0]   hi_q;
    logic            changed_q;
    logic [PW-1:0]   pass_q;
    logic            val_q;
    cls_e            cls_q  [H][W];
    logic [MW-1:0]   edge_q [H][W];

    logic            start;
    logic            border;
    logic            nbr_strong;
    logic            promote;
    logic [MW-1:0]   mag;
    logic [XW-1:0]   xm, xp;
    logic [YW-1:0]   ym, yp;
    logic [PW-1:0]   pass_d;
    cls_e            cls_d;

    assign start  = thin_val & ~thin_val_q;
    assign mag    = thin_edge[y_q][x_q];
    assign border = (x_q == '0) || (x_q == X_LAST) ||
                    (y_q == '0) || (y_q == Y_LAST);
    assign xm     = x_q - 1'b1;
    assign xp     = x_q + 1'b1;
    assign ym     = y_q - 1'b1;
    assign yp     = y_q + 1'b1;
    assign pass_d = pass_q + 1'b1;

    always_comb begin
        cls_d = C_NONE;
        if (!border) begin
            if (mag >= hi_q)
                cls_d = C_STRONG;
            else if (mag >= lo_q)
                cls_d = C_WEAK;
        end
    end

    // Only meaningful in HYST, where x/y are interior so neighbours are in range.
    assign nbr_strong = (cls_q[ym][xm] == C_STRONG) ||
                        (cls_q[ym][x_q] == C_STRONG) ||
                        (cls_q[ym][xp] == C_STRONG) ||
                        (cls_q[y_q][xm] == C_STRONG) ||
                        (cls_q[y_q][xp] == C_STRONG) ||
                        (cls_q[yp][xm] == C_STRONG) ||
                        (cls_q[yp][x_q] == C_STRONG) ||
                        (cls_q[yp][xp] == C_STRONG);
    assign promote = (cls_q[y_q][x_q] == C_WEAK) && nbr_strong;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            thin_val_q <= 1'b0;
            x_q        <= '0;
            y_q        <= '0;
            lo_q       <= '0;
            hi_q       <= '0;
            changed_q  <= 1'b0;
            pass_q     <= '0;
            val_q      <= 1'b0;
            for (int y = 0; y < H; y++) begin
                for (int x = 0; x < W; x++) begin
                    cls_q[y][x]  <= C_NONE;
                    edge_q[y][x] <= '0;
                end
            end
        end else begin
            thin_val_q <= thin_val;
            unique case (state_q)
                S_IDLE: begin
                    if (start) begin
                        lo_q    <= (low_thr < high_thr) ? low_thr : high_thr;
                        hi_q    <= high_thr;
                        val_q   <= 1'b0;
                        pass_q  <= '0;
                        x_q     <= '0;
                        y_q     <= '0;
                        state_q <= S_CLASSIFY;
                    end
                end
                S_CLASSIFY: begin
                    cls_q[y_q][x_q] <= cls_d;
                    if (x_q == X_LAST) begin
                        if (y_q == Y_LAST) begin
                            x_q       <= X_ONE;
                            y_q       <= Y_ONE;
                            changed_q <= 1'b0;
                            state_q   <= S_HYST;
                        end else begin
                            x_q <= '0;
                            y_q <= yp;
                        end
                    end else begin
                        x_q <= xp;
                    end
                end
                S_HYST: begin
                    if (promote) begin
                        cls_q[y_q][x_q] <= C_STRONG;
                        changed_q       <= 1'b1;
                    end
                    if (x_q == X_HLAST) begin
                        x_q <= X_ONE;
                        if (y_q == Y_HLAST) begin
                            pass_q    <= pass_d;
                            y_q       <= Y_ONE;
                            changed_q <= 1'b0;
                            // Stop on a quiet pass or at the cap; leftover WEAK is dropped.
                            if (!(changed_q || promote) || (pass_d == P_MAX)) begin
                                x_q     <= '0;
                                y_q     <= '0;
                                state_q <= S_OUTPUT;
                            end
                        end else begin
                            y_q <= yp;
                        end
                    end else begin
                        x_q <= xp;
                    end
                end
                S_OUTPUT: begin
                    edge_q[y_q][x_q] <= (cls_q[y_q][x_q] == C_STRONG) ? '1 : '0;
                    if (x_q == X_LAST) begin
                        x_q <= '0;
                        if (y_q == Y_LAST) begin
                            y_q     <= '0;
                            val_q   <= 1'b1;
                            state_q <= S_IDLE;
                        end else begin
                            y_q <= yp;
                        end
                    end else begin
                        x_q <= xp;
                    end
                end
            endcase
        end
    end

    assign busy       = (state_q != S_IDLE);
    assign canny_val  = val_q;
    assign canny_edge = edge_q;
    assign pass_cnt   = pass_q;

endmodule
